fetch_pc_unit: RTL and testbench

//  Owns the program counter and instruction fetch for the monocycle core.

---
 rtl/core_pkg.sv | 28 ++
 rtl/fetch_pc_unit_next_pc.sv | 29 ++
 rtl/fetch_pc_unit.sv | 110 +++++++++++
 tb/tb_fetch_pc_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the fetch/PC path and branch_unit.
//  - FSM state encodings for fetch_pc_unit
//  - BR_* branch-op encodings (must match branch_unit)
//  - INSTR_ALIGN_MASK: low PC bits that must be zero for a legal fetch
package core_pkg;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_TRAP = 2'd3;

    typedef enum logic [4:0] {
        BR_BEQ  = 5'b00000,
        BR_BNE  = 5'b00001,
        BR_BLT  = 5'b00100,
        BR_BGE  = 5'b00101,
        BR_BLTU = 5'b00110,
        BR_BGEU = 5'b00111,
        BR_JUMP = 5'b11111
    } br_op_e;

    localparam logic [31:0] INSTR_ALIGN_MASK = 32'h0000_0003;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return |(addr & INSTR_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc.sv
// next_pc_calc: combinational next-PC selection for a retiring instruction.
//  pc, imm, rs1_data  in  32  current pc, sign-extended offset, jalr base
//  branch, is_jalr    in  1   taken decision, rs1-relative target
//  next_pc            out 32  selected next PC (modulo 2^32)
//  misaligned         out 1   next_pc not 4-byte aligned
module next_pc_calc
    import core_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic        branch,
    input  logic        is_jalr,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] target;

    always_comb begin
        target = (is_jalr ? rs1_data : pc) + imm;
        // jalr clears bit 0 only; bit 1 can still leave the target misaligned
        if (is_jalr)
            target = target & ~32'h1;
        next_pc    = branch ? target : pc + 32'd4;
        misaligned = is_misaligned(next_pc);
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and instruction fetch for the monocycle core.
// Fetches one instruction per REQ/WAIT/EXEC round over imem req/gnt/rvalid,
// holds it for the core, and on retire moves pc to the selected next PC.
// A misaligned taken target traps sticky until rst.
//  clk, rst                  clock, synchronous active-high reset
//  imem_req/addr             fetch request (held until gnt) and address (= pc)
//  imem_gnt/rvalid/rdata     grant, read-data valid, instruction word
//  instr, instr_valid, pc    latched instruction, valid flag, its address
//  pc_plus4                  link value pc+4
//  retire, branch, is_jalr,
//  imm, rs1_data             retirement and next-PC inputs (sampled with retire)
//  misalign_trap, trap_pc    sticky trap flag and faulting pc
//  retired_cnt               retired-instruction count, wraps
module fetch_pc_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             retire,
    input  logic             branch,
    input  logic             is_jalr,
    input  logic [31:0]      imm,
    input  logic [31:0]      rs1_data,
    output logic             misalign_trap,
    output logic [31:0]      trap_pc,
    output logic [CNT_W-1:0] retired_cnt
);

    logic [1:0]  state, state_nxt;
    logic [31:0] next_pc;
    logic        next_misaligned;
    logic        do_retire;

    next_pc_calc u_next_pc (
        .pc         (pc),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .branch     (branch),
        .is_jalr    (is_jalr),
        .next_pc    (next_pc),
        .misaligned (next_misaligned)
    );

    assign do_retire = (state == S_EXEC) && retire;

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_REQ;
        else
            state <= state_nxt;
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ:   if (imem_gnt)    state_nxt = S_WAIT;
            S_WAIT:  if (imem_rvalid) state_nxt = S_EXEC;
            S_EXEC:  if (retire)      state_nxt = next_misaligned ? S_TRAP : S_REQ;
            default: state_nxt = S_TRAP;
        endcase
    end

    // outputs; req is gated by rst so nothing is requested while held in reset
    always_comb begin
        imem_req    = (state == S_REQ) && !rst;
        instr_valid = (state == S_EXEC);
    end

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // datapath registers; rvalid outside S_WAIT is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            instr         <= '0;
            misalign_trap <= 1'b0;
            trap_pc       <= '0;
            retired_cnt   <= '0;
        end else begin
            if (state == S_WAIT && imem_rvalid)
                instr <= imem_rdata;
            if (do_retire) begin
                if (next_misaligned) begin
                    // faulting instruction is not counted and pc stays on it
                    misalign_trap <= 1'b1;
                    trap_pc       <= pc;
                end else begin
                    pc          <= next_pc;
                    retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [31:0]      imem_rdata;
    logic [31:0]      instr;
    logic             instr_valid;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             retire;
    logic             branch;
    logic             is_jalr;
    logic [31:0]      imm;
    logic [31:0]      rs1_data;
    logic             misalign_trap;
    logic [31:0]      trap_pc;
    logic [CNT_W-1:0] retired_cnt;

    fetch_pc_unit #(.RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .retire        (retire),
        .branch        (branch),
        .is_jalr       (is_jalr),
        .imm           (imm),
        .rs1_data      (rs1_data),
        .misalign_trap (misalign_trap),
        .trap_pc       (trap_pc),
        .retired_cnt   (retired_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;
    logic [31:0]      addr_q[$];   // expected fetch addresses, in order
    logic [CNT_W-1:0] exp_cnt;
    logic [31:0]      exp_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one cycle; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one fetch: gnt after gnt_dly cycles, rvalid rv_dly cycles after the WAIT entry
    task automatic fetch(input logic [31:0] word, input int gnt_dly, input int rv_dly);
        logic [31:0] a;
        a = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hxxxx_xxxx;
        if (addr_q.size() == 0 && a === 32'hxxxx_xxxx) begin
            vectors++; errs++;
            $error("FAIL scoreboard_empty observed=none expected=address");
        end
        exp_pc = a;
        for (int i = 0; i < gnt_dly; i++) begin
            chk("req_held", {31'b0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, a);
            tick();
        end
        chk("req", {31'b0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, a);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        for (int i = 0; i < rv_dly; i++) begin
            chk("wait_req", {31'b0, imem_req}, 32'd0);
            chk("wait_ivld", {31'b0, instr_valid}, 32'd0);
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        chk("instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("instr", instr, word);
        chk("pc", pc, a);
        chk("pc_plus4", pc_plus4, a + 32'd4);
    endtask

    // retire current instruction; exp_next is the target expected by the test plan
    task automatic do_retire(input logic br, input logic jr, input logic [31:0] im,
                             input logic [31:0] r1, input logic [31:0] exp_next,
                             input logic exp_trap);
        retire = 1'b1; branch = br; is_jalr = jr; imm = im; rs1_data = r1;
        if (!exp_trap) begin
            addr_q.push_back(exp_next);
            exp_cnt = exp_cnt + 1'b1;
        end
        tick();
        retire = 1'b0; branch = 1'b0; is_jalr = 1'b0; imm = 32'h0; rs1_data = 32'h0;
        chk("retired_cnt", {29'b0, retired_cnt}, {29'b0, exp_cnt});
        chk("trap", {31'b0, misalign_trap}, {31'b0, exp_trap});
        chk("req_after_retire", {31'b0, imem_req}, {31'b0, !exp_trap});
        chk("ivld_after_retire", {31'b0, instr_valid}, 32'd0);
    endtask

    task automatic check_reset_state();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_ivld", {31'b0, instr_valid}, 32'd0);
        chk("rst_trap", {31'b0, misalign_trap}, 32'd0);
        chk("rst_trap_pc", trap_pc, 32'h0);
        chk("rst_cnt", {29'b0, retired_cnt}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        retire = 1'b0; branch = 1'b0; is_jalr = 1'b0; imm = 32'h0; rs1_data = 32'h0;
        exp_cnt = '0;
        tick(); tick();
        chk("req_in_rst", {31'b0, imem_req}, 32'd0);
        rst = 1'b0;
        #1;
        check_reset_state();
        addr_q.push_back(32'h0);

        // 1: immediate gnt/rvalid, sequential retire
        fetch(32'h0000_0013, 0, 0);
        do_retire(1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0);
        // walk to 0x100 with a forward branch
        fetch(32'h0000_0063, 0, 0);
        do_retire(1'b1, 1'b0, 32'h0000_00FC, 32'h0, 32'h100, 1'b0);
        // 2: backward branch from 0x100
        fetch(32'hFE00_0EE3, 0, 0);
        do_retire(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h0F0, 1'b0);

        // 5: slow gnt and rvalid; a retire during WAIT must be ignored
        begin : slow_fetch
            logic [31:0] a;
            a = addr_q.pop_front();
            for (int i = 0; i < 5; i++) begin
                chk("slow_req", {31'b0, imem_req}, 32'd1);
                chk("slow_addr", imem_addr, a);
                tick();
            end
            imem_gnt = 1'b1;
            tick();
            imem_gnt = 1'b0;
            retire = 1'b1; branch = 1'b1; imm = 32'h40;
            tick();
            retire = 1'b0; branch = 1'b0; imm = 32'h0;
            chk("retire_in_wait_pc", pc, a);
            chk("retire_in_wait_cnt", {29'b0, retired_cnt}, {29'b0, exp_cnt});
            tick(); tick();
            chk("slow_wait_req", {31'b0, imem_req}, 32'd0);
            imem_rvalid = 1'b1; imem_rdata = 32'h0000_0067;
            tick();
            // stray second beat in EXEC must not overwrite instr
            imem_rdata = 32'hBAD0_BAD0;
            chk("slow_ivld", {31'b0, instr_valid}, 32'd1);
            chk("slow_instr", instr, 32'h0000_0067);
            tick();
            imem_rvalid = 1'b0; imem_rdata = 32'h0;
            chk("instr_once", instr, 32'h0000_0067);
            chk("slow_pc", pc, 32'h0F0);
        end
        // 3: jalr with bit 0 set is cleared -> aligned
        do_retire(1'b1, 1'b1, 32'h2, 32'h2003, 32'h2004, 1'b0);
        fetch(32'h0000_8067, 0, 1);
        // 4: jalr landing on bit 1 -> trap
        do_retire(1'b1, 1'b1, 32'h2, 32'h2000, 32'h0, 1'b1);
        chk("trap_pc", trap_pc, 32'h2004);
        chk("trap_pc_unchanged", pc, 32'h2004);
        imem_gnt = 1'b1; imem_rvalid = 1'b1; retire = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("trap_req", {31'b0, imem_req}, 32'd0);
            chk("trap_sticky", {31'b0, misalign_trap}, 32'd1);
            chk("trap_ivld", {31'b0, instr_valid}, 32'd0);
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0; retire = 1'b0;

        // 6: reset clears trap; reset in WAIT, stray rvalid afterwards dropped
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_reset_state();
        exp_cnt = '0;
        addr_q.delete();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("in_wait", {31'b0, imem_req}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        chk("stray_rvalid_ivld", {31'b0, instr_valid}, 32'd0);
        chk("stray_rvalid_instr", instr, 32'h0);
        chk("restart_req", {31'b0, imem_req}, 32'd1);
        addr_q.push_back(32'h0);
        fetch(32'h0000_006F, 0, 0);
        do_retire(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1'b0);
        fetch(32'h0000_0013, 0, 0);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        do_retire(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        // retired counter wrap at 2^CNT_W (exp_cnt is 2 here, 7 more -> 1)
        for (int i = 0; i < 7; i++) begin
            fetch(32'h0000_0013, i % 2, (i + 1) % 3);
            do_retire(1'b0, 1'b0, 32'h0, 32'h0, exp_pc + 32'd4, 1'b0);
        end
        chk("cnt_wrapped", {29'b0, retired_cnt}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
